// File: rtl/fifo_pkg.sv
// Shared definitions for the parametrised single-clock FIFO.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package fifo_pkg;

    // Read-mode selectors for the FWFT parameter
    localparam int FIFO_STD  = 0;
    localparam int FIFO_FWFT = 1;

    // Status flags, grouped so monitors can sample them as one word
    typedef struct packed {
        logic empty;
        logic full;
        logic almost_full;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } fifo_status_t;

    // Address width for a given power-of-two depth
    function automatic int addr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// DATA_W x DEPTH register array: one synchronous write port, one async read port.
// Latency: write lands on the rising edge; read data is combinational from raddr_i.
// Backpressure: none; the owner gates we_i with its own acceptance logic.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                      clk_i,
    input  logic                      we_i,
    input  logic [addr_w(DEPTH)-1:0]  waddr_i,
    input  logic [DATA_W-1:0]         wdata_i,
    input  logic [addr_w(DEPTH)-1:0]  raddr_i,
    output logic [DATA_W-1:0]         rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Storage is deliberately not reset; only the pointers define validity
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds and optional FWFT read.
// Latency: flags/count valid one cycle after the causing edge; std data one cycle after rd accept.
// Backpressure: writes rejected when full (unless a read frees a slot), reads rejected when empty.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = 14,
    parameter int AE_THRESH = 2,
    parameter int FWFT      = 0
) (
    input  logic                         clock,
    input  logic                         rst,
    input  logic                         wr,
    input  logic                         rd,
    input  logic [DATA_W-1:0]            data_in,
    output logic [DATA_W-1:0]            data_out,
    output logic                         empty,
    output logic                         full,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int AW = addr_w(DEPTH);
    localparam int CW = AW + 1;

    // Reject illegal configurations at elaboration
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("sync_fifo_param: DEPTH must be a power of two and at least 2");
    end
    if ((AF_THRESH < 1) || (AF_THRESH > DEPTH)) begin : g_bad_af
        $error("sync_fifo_param: AF_THRESH must lie in 1..DEPTH");
    end
    if ((AE_THRESH < 0) || (AE_THRESH > DEPTH - 1)) begin : g_bad_ae
        $error("sync_fifo_param: AE_THRESH must lie in 0..DEPTH-1");
    end
    if ((FWFT != FIFO_STD) && (FWFT != FIFO_FWFT)) begin : g_bad_mode
        $error("sync_fifo_param: FWFT must be 0 or 1");
    end

    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic [CW-1:0]     count_d;
    fifo_status_t      status_q;
    fifo_status_t      status_d;
    logic              wr_acc;
    logic              rd_acc;
    logic [DATA_W-1:0] rd_dat;

    // A read on a full FIFO frees the slot the concurrent write needs
    assign wr_acc = wr & (~status_q.full | rd);
    assign rd_acc = rd & ~status_q.empty;

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk_i   (clock),
        .we_i    (wr_acc),
        .waddr_i (wr_ptr_q),
        .wdata_i (data_in),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_dat)
    );

    // Next occupancy and the flags derived from it, registered below
    always_comb begin
        count_d               = count_q + CW'(wr_acc) - CW'(rd_acc);
        status_d              = '0;
        status_d.empty        = (count_d == '0);
        status_d.full         = (count_d == CW'(DEPTH));
        status_d.almost_full  = (count_d >= CW'(AF_THRESH));
        status_d.almost_empty = (count_d <= CW'(AE_THRESH));
        status_d.overflow     = wr & ~wr_acc;
        status_d.underflow    = rd & ~rd_acc;
    end

    // Pointers, occupancy and status; pointers wrap by natural overflow
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            wr_ptr_q              <= '0;
            rd_ptr_q              <= '0;
            count_q               <= '0;
            status_q              <= '0;
            status_q.empty        <= 1'b1;
            status_q.almost_empty <= 1'b1;
        end else begin
            if (wr_acc) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q  <= count_d;
            status_q <= status_d;
        end
    end

    if (FWFT == FIFO_FWFT) begin : g_fwft
        // Head word shown directly; forced to zero while empty so reset reads 0
        assign data_out = status_q.empty ? '0 : rd_dat;
    end else begin : g_std
        logic [DATA_W-1:0] dout_q;

        // Registered read: capture the head on an accepted read, hold otherwise
        always_ff @(posedge clock or negedge rst) begin
            if (!rst) begin
                dout_q <= '0;
            end else if (rd_acc) begin
                dout_q <= rd_dat;
            end
        end

        assign data_out = dout_q;
    end

    assign empty        = status_q.empty;
    assign full         = status_q.full;
    assign almost_full  = status_q.almost_full;
    assign almost_empty = status_q.almost_empty;
    assign overflow     = status_q.overflow;
    assign underflow    = status_q.underflow;
    assign count        = count_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: standard-mode instance plus an FWFT instance.
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: exercises overflow/underflow rejection and full/empty simultaneous access.
module tb_sync_fifo_param;

    localparam int DW = 8;
    localparam int DP = 16;
    localparam int CW = 5;

    logic          clock = 1'b0;
    logic          rst   = 1'b0;
    logic          wr    = 1'b0;
    logic          rd    = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] data_out;
    logic          empty, full, almost_full, almost_empty, overflow, underflow;
    logic [CW-1:0] count;

    logic          f_rst = 1'b0;
    logic          f_wr  = 1'b0;
    logic          f_rd  = 1'b0;
    logic [DW-1:0] f_din = '0;
    logic [DW-1:0] f_dout;
    logic          f_empty, f_full, f_af, f_ae, f_ov, f_un;
    logic [CW-1:0] f_count;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    sync_fifo_param #(
        .DATA_W(DW), .DEPTH(DP), .AF_THRESH(14), .AE_THRESH(2), .FWFT(0)
    ) u_dut (
        .clock(clock), .rst(rst), .wr(wr), .rd(rd), .data_in(data_in),
        .data_out(data_out), .empty(empty), .full(full),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .count(count), .overflow(overflow), .underflow(underflow)
    );

    sync_fifo_param #(
        .DATA_W(DW), .DEPTH(DP), .AF_THRESH(14), .AE_THRESH(2), .FWFT(1)
    ) u_dut_fwft (
        .clock(clock), .rst(f_rst), .wr(f_wr), .rd(f_rd), .data_in(f_din),
        .data_out(f_dout), .empty(f_empty), .full(f_full),
        .almost_full(f_af), .almost_empty(f_ae),
        .count(f_count), .overflow(f_ov), .underflow(f_un)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #12;
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_ae", almost_empty, 1);
        check("rst_full", full, 0);
        check("rst_af", almost_full, 0);
        check("rst_ov", overflow, 0);
        check("rst_un", underflow, 0);
        check("rst_dout", data_out, 0);
        check("f_rst_empty", f_empty, 1);
        check("f_rst_full", f_full, 0);
        rst   = 1'b1;
        f_rst = 1'b1;

        // Test 1 + 5: fill 0x01..0x10, sweeping count upward
        for (int i = 1; i <= 16; i++) begin
            wr = 1'b1; data_in = DW'(i);
            tick();
            check("fill_count", count, i);
            check("fill_full", full, (i == 16));
            check("fill_empty", empty, 0);
            check("fill_af", almost_full, (i >= 14));
            check("fill_ae", almost_empty, (i <= 2));
        end
        wr = 1'b0;
        // Drain, sweeping count back down
        for (int i = 1; i <= 16; i++) begin
            rd = 1'b1;
            tick();
            check("drain_data", data_out, i);
            check("drain_count", count, 16 - i);
            check("drain_empty", empty, (i == 16));
            check("drain_af", almost_full, ((16 - i) >= 14));
            check("drain_ae", almost_empty, ((16 - i) <= 2));
        end
        rd = 1'b0;

        // Test 2: overflow on write to full FIFO
        for (int i = 1; i <= 16; i++) begin
            wr = 1'b1; data_in = DW'(i);
            tick();
        end
        data_in = 8'hFF;
        tick();
        check("ovf_pulse", overflow, 1);
        check("ovf_count", count, 16);
        wr = 1'b0;
        tick();
        check("ovf_clear", overflow, 0);
        rd = 1'b1;
        tick();
        check("ovf_first_rd", data_out, 8'h01);
        check("ovf_rd_count", count, 15);
        rd = 1'b0; wr = 1'b1; data_in = 8'h11;
        tick();
        check("refill_full", full, 1);

        // Test 4: full with simultaneous wr/rd for 20 cycles; contents 0x02..0x11
        for (int k = 0; k < 20; k++) begin
            wr = 1'b1; rd = 1'b1; data_in = DW'(8'h20 + k);
            tick();
            check("full_rw_data", data_out, (k < 16) ? (8'h02 + k) : (8'h20 + k - 16));
            check("full_rw_count", count, 16);
            check("full_rw_ov", overflow, 0);
            check("full_rw_un", underflow, 0);
        end
        wr = 1'b0;
        // Remaining contents are 0x24..0x33
        for (int k = 0; k < 16; k++) begin
            rd = 1'b1;
            tick();
            check("wrap_drain", data_out, 8'h24 + k);
        end
        rd = 1'b0;
        check("wrap_empty", empty, 1);

        // Test 3: wr+rd on empty FIFO
        wr = 1'b1; rd = 1'b1; data_in = 8'hA5;
        tick();
        check("e_rw_un", underflow, 1);
        check("e_rw_count", count, 1);
        check("e_rw_empty", empty, 0);
        wr = 1'b0; rd = 1'b0;
        tick();
        check("e_rw_un_clear", underflow, 0);
        rd = 1'b1;
        tick();
        check("e_rw_data", data_out, 8'hA5);
        check("e_rw_count0", count, 0);
        tick();
        check("e_rd_un", underflow, 1);
        check("e_rd_hold", data_out, 8'hA5);
        rd = 1'b0;

        // Test 6: FWFT head visible without rd
        f_wr = 1'b1; f_din = 8'h3C;
        tick();
        f_wr = 1'b0;
        check("fwft_head", f_dout, 8'h3C);
        check("fwft_count", f_count, 1);
        for (int i = 1; i <= 4; i++) begin
            f_wr = 1'b1; f_din = DW'(8'h40 + i);
            tick();
        end
        f_wr = 1'b0;
        check("fwft_head_hold", f_dout, 8'h3C);
        f_rd = 1'b1;
        tick();
        f_rd = 1'b0;
        check("fwft_pop", f_dout, 8'h41);
        f_wr = 1'b1; f_din = 8'h45;
        tick();
        f_wr = 1'b0;
        check("fwft_count5", f_count, 5);
        // Asynchronous reset mid-stream, between clock edges
        #2;
        f_rst = 1'b0;
        #1;
        check("fwft_arst_count", f_count, 0);
        check("fwft_arst_empty", f_empty, 1);
        f_rst = 1'b1;
        f_wr = 1'b1; f_din = 8'h77;
        tick();
        f_wr = 1'b0;
        check("fwft_post_rst_data", f_dout, 8'h77);
        check("fwft_post_rst_count", f_count, 1);
        f_rd = 1'b1;
        tick();
        f_rd = 1'b0;
        check("fwft_post_rst_empty", f_empty, 1);
        check("fwft_post_rst_un", f_un, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Parametrised successor to the team's single-clock FIFO. Width and depth are configurable.
- Adds occupancy count, programmable almost-full/almost-empty thresholds, overflow/underflow pulses, and a selectable first-word-fall-through (FWFT) read mode.
- Sits between a producer and a consumer in one clock domain. It is a drop-in for the existing FIFO port set, plus the extra status ports.

Parameters:
- DATA_W, 8: data word width in bits.
- DEPTH, 16: number of entries; must be a power of two, at least 2.
- AF_THRESH, 14: almost_full asserts when count >= AF_THRESH; legal range 1..DEPTH.
- AE_THRESH, 2: almost_empty asserts when count <= AE_THRESH; legal range 0..DEPTH-1.
- FWFT, 0: 0 = standard registered read, 1 = first-word-fall-through.

Ports:
- clock  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- wr  in  1  write request.
- rd  in  1  read request.
- data_in  in  DATA_W  write data.
- data_out  out  DATA_W  read data.
- empty  out  1  FIFO holds 0 entries.
- full  out  1  FIFO holds DEPTH entries.
- almost_full  out  1  count >= AF_THRESH.
- almost_empty  out  1  count <= AE_THRESH.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  out  1  one-cycle pulse: a write was rejected.
- underflow  out  1  one-cycle pulse: a read was rejected.

Behaviour:
- Reset (rst=0, takes effect immediately, independent of clock):
  - Pointers = 0, count = 0, data_out = 0.
  - empty = 1, almost_empty = 1, full = 0, almost_full = 0, overflow = 0, underflow = 0.
  - Memory contents are not reset.
  - Reset asserted mid-operation discards all contents. The first write after rst deasserts lands at address 0.
- Acceptance is evaluated on pre-edge state:
  - wr_acc = wr & (!full | rd).
  - rd_acc = rd & !empty.
- Simultaneous accesses:
  - Full with wr and rd both high: both accepted, count unchanged, no overflow.
  - Empty with wr and rd both high: write accepted, read rejected, underflow pulses, count becomes 1.
- Rejected accesses:
  - wr & !wr_acc causes overflow = 1 for the next cycle only; memory, pointer and count are unchanged.
  - rd & !rd_acc causes underflow = 1 for the next cycle only.
- Pointers:
  - $clog2(DEPTH) bits each; wrap from DEPTH-1 to 0 by natural overflow.
  - wr_acc writes mem[wr_ptr] and increments wr_ptr.
  - rd_acc increments rd_ptr.
- Count:
  - count_next = count + wr_acc - rd_acc.
  - empty, full, almost_full and almost_empty are registered from count_next, so they are valid the cycle after the causing edge. No combinational path runs from inputs to flags.
- Standard read (FWFT=0):
  - On rd_acc, data_out <= mem[rd_ptr], so data appears one cycle after the accepting edge.
  - data_out holds its value when no read is accepted.
- FWFT read (FWFT=1):
  - data_out continuously shows mem[rd_ptr] while !empty, so the head word is visible in the cycle after the write that made the FIFO non-empty.
  - rd_acc pops the head, and the next word appears after the edge.
  - data_out is don't-care while empty; the bench must not check it.
- Read-during-write to the same address (occurs only when count is 0 or DEPTH) never returns stale data: the acceptance rules above prevent a read of an unwritten slot.
- Parameter checks: an elaboration-time error is raised if DEPTH is not a power of two, or if either threshold is out of range.

Decomposition:
- Package fifo_pkg:
  - addr_w(depth) function returning $clog2(depth).
  - Read-mode constants FIFO_STD = 0 and FIFO_FWFT = 1.
  - Shared status struct (empty, full, almost_full, almost_empty, overflow, underflow) for bench monitors.
- Sub-module fifo_mem:
  - DATA_W x DEPTH register array with one synchronous write port and one asynchronous read port.
  - The top level provides the registered data_out in standard mode.
- The existing fifo_if interface is extended with the new status signals and count.

Test Plan:
1. Reset, then write 0x01..0x10 (16 words, DEPTH=16), then read 16 -> data_out returns 0x01..0x10 in order. full goes high after the 16th write, count = 16, empty rises after the last read.
2. Fill to 16, then one extra write -> overflow pulses for exactly 1 cycle, count stays 16, and the next read returns 0x01.
3. With the FIFO empty, drive wr=1 and rd=1 with data_in=0xA5 -> underflow pulses once, count = 1. Then read -> 0xA5.
4. With the FIFO full, drive wr and rd for 20 cycles -> count stays 16, no overflow/underflow pulses, and the read-pointer/write-pointer wrap is exercised.
5. Sweep count 0..16..0 -> almost_full high exactly for count >= 14, almost_empty high exactly for count <= 2.
6. With FWFT=1: write 0x3C -> data_out = 0x3C with no rd. Then assert rst low mid-stream with 5 words stored -> count = 0 and empty = 1 immediately, and the next write/read round-trip works.
